tmds_channel_rx: RTL and testbench
==================================

Name: tmds_channel_rx

Overview:
- Receive-side counterpart of the team's TMDS transmit path.
- Takes one channel's 10-bit parallel words, delivered each pixel clock by an ISERDES-based 1:10 deserializer (not part of this block).
- Locks word alignment by hunting for DVI control tokens and issuing bitslip requests to the deserializer.
- Decodes TMDS 8b/10b back to 8-bit pixel data plus c0/c1/de; three instances (B/G/R) form a DVI receiver at 40 MHz.

Parameters:
- CTRL_RUN, 8: consecutive identical control tokens required to declare lock.
- SEARCH_TIMEOUT, 2048: cycles without a qualifying token run before a bitslip is issued.
- SLIP_SETTLE, 4: cycles ignored after a bitslip pulse while the deserializer re-frames.
- LOCK_TIMEOUT, 4096: cycles without any control token while locked before lock is dropped.

Ports:
- pix_clk  in  1  pixel clock, 40 MHz, the only clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  10  raw deserialized word, bit 0 first on the wire.
- bitslip  out  1  one-cycle pulse: deserializer rotates framing by one bit.
- aligned  out  1  high while in LOCKED.
- dout  out  8  decoded pixel data.
- c0  out  1  decoded control bit 0 (hsync on the blue channel).
- c1  out  1  decoded control bit 1 (vsync on the blue channel).
- de  out  1  data enable (active video).

Behaviour:
- Interface fixed: one clock, pix_clk; reset rst is asynchronous and active-high. All registers clear on rst assertion with no clock required.
- Reset values: bitslip=0, aligned=0, dout=0, c0=0, c1=0, de=0; FSM in SEARCH; all counters 0.
- Control token detect (combinational on din):
  - 1101010100 -> {c1,c0}=00
  - 0010101011 -> 01
  - 0101010100 -> 10
  - 1010101011 -> 11
  - Any other word is data.
- Data decode:
  - t[7:0] = din[9] ? ~din[7:0] : din[7:0].
  - d[0] = t[0].
  - For i=1..7: d[i] = din[8] ? t[i]^t[i-1] : ~(t[i]^t[i-1]).
- Output register, latency exactly 1 cycle from din:
  - If aligned and din is a token: de=0, c0/c1 = token bits, dout=0.
  - If aligned and din is data: de=1, dout=d, c0/c1 hold their previous values.
  - If not aligned: de=0, dout=0, c0=c1=0.
- FSM SEARCH:
  - run counter increments when din is a token equal to the previous cycle's word, else loads 1 on a token, 0 otherwise.
  - run reaching CTRL_RUN -> LOCKED; aligned rises next cycle.
  - Timer counts cycles in SEARCH, cleared on entry. At SEARCH_TIMEOUT-1 without lock -> bitslip=1 for exactly one cycle, go to SLIP_WAIT.
  - Lock qualification takes priority over timeout in the same cycle.
- FSM SLIP_WAIT:
  - Ignore din for SLIP_SETTLE cycles, then -> SEARCH with run and timer cleared.
  - bitslip never pulses again before return to SEARCH.
- FSM LOCKED:
  - Idle counter clears on every token, increments otherwise.
  - Reaching LOCK_TIMEOUT -> SEARCH. aligned falls on the cycle the state leaves LOCKED; outputs are then forced as not aligned.
- Counters saturate and never wrap. Widths are sized by $clog2 of each parameter plus 1.
- rst mid-operation (including mid SLIP_WAIT or during a bitslip pulse) aborts immediately; bitslip drops asynchronously.

Optional Feature:
- Macro TMDS_RX_DISP_CHECK_EN.
- When defined:
  - Adds output disp_err (1 bit, reset 0) and internal 7-bit signed accumulator acc.
  - On each aligned data word, acc += (ones(din) - zeros(din)), saturating at ±63.
  - acc clears on any token.
  - disp_err pulses one cycle, aligned with the corresponding dout, when |acc| > 16 after the update.
- When undefined: no port, no logic.

Test Plan:
- Aligned token stream: 10 x 1101010100 then 0010101011 -> aligned=1 after the 8th token. Next-cycle outputs c0=0,c1=0,de=0, then c0=1,c1=0.
- Data decode: lock, then feed encoder outputs for bytes 0x00, 0xFF, 0x10, 0xA5 -> dout equals those values one cycle later, de=1, c0/c1 held.
- Misaligned input: 1-bit-rotated token stream for 2048 cycles -> bitslip pulse width 1 at cycle 2047; no further pulse for ≥4 cycles; after the model rotates, lock follows 8 tokens later.
- Loss of lock: after lock, drive 4096 data words with no tokens -> aligned falls on cycle 4096; de/dout forced to 0 one cycle later.
- Async reset: assert rst between pix_clk edges during the bitslip pulse and while locked -> all outputs 0 immediately; SEARCH restarts on release.
- With TMDS_RX_DISP_CHECK_EN: 3 consecutive data words 1111111100 (+6 each) -> disp_err=1 on the 3rd word's output cycle (acc=18); a following token clears acc.

Source files
------------

// File: rtl/tmds_channel_rx.sv
// rtl/tmds_channel_rx.sv - TMDS channel receiver: word alignment and 8b/10b decode (optional TMDS_RX_DISP_CHECK_EN)
module tmds_channel_rx #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_SETTLE    = 4,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic       pix_clk,
    input  logic       rst,
    input  logic [9:0] din,
    output logic       bitslip,
    output logic       aligned,
    output logic [7:0] dout,
    output logic       c0,
    output logic       c1,
    output logic       de
`ifdef TMDS_RX_DISP_CHECK_EN
    ,
    output logic       disp_err
`endif
);
    localparam int RUN_W  = $clog2(CTRL_RUN) + 1;
    localparam int TMR_W  = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int SLIP_W = $clog2(SLIP_SETTLE) + 1;
    localparam int IDLE_W = $clog2(LOCK_TIMEOUT) + 1;

    typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [SLIP_W-1:0]  slip_q, slip_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [9:0]         prev_q;
    logic               bitslip_q, bitslip_d;
    logic [7:0]         dout_q, dout_d;
    logic               c0_q, c0_d, c1_q, c1_d, de_q, de_d;

    logic               is_tok;
    logic [1:0]         tok_c;
    logic [7:0]         t, dec;
    logic               locked_now;

    assign locked_now = (state_q == LOCKED);

    // Control token recognition; tok_c is {c1,c0}
    always_comb begin
        is_tok = 1'b1;
        tok_c  = 2'b00;
        case (din)
            10'b1101010100: tok_c = 2'b00;
            10'b0010101011: tok_c = 2'b01;
            10'b0101010100: tok_c = 2'b10;
            10'b1010101011: tok_c = 2'b11;
            default:        is_tok = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain
    always_comb begin
        t      = din[9] ? ~din[7:0] : din[7:0];
        dec    = '0;
        dec[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = din[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
    end

    // Alignment FSM: hunt for a run of identical tokens, slip on timeout, drop lock when tokens vanish
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        timer_d   = timer_q;
        slip_d    = slip_q;
        idle_d    = idle_q;
        bitslip_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (is_tok && din == prev_q) begin
                    run_d = (run_q != '1) ? run_q + 1'b1 : run_q;
                end else if (is_tok) begin
                    run_d = RUN_W'(1);
                end else begin
                    run_d = '0;
                end
                if (run_d >= RUN_W'(CTRL_RUN)) begin
                    state_d = LOCKED;
                    run_d   = '0;
                    timer_d = '0;
                    idle_d  = '0;
                end else if (timer_q == TMR_W'(SEARCH_TIMEOUT - 1)) begin
                    state_d   = SLIP_WAIT;
                    bitslip_d = 1'b1;
                    slip_d    = '0;
                    run_d     = '0;
                    timer_d   = '0;
                end else begin
                    timer_d = (timer_q != '1) ? timer_q + 1'b1 : timer_q;
                end
            end
            SLIP_WAIT: begin
                run_d   = '0;
                timer_d = '0;
                if (slip_q == SLIP_W'(SLIP_SETTLE - 1)) begin
                    state_d = SEARCH;
                    slip_d  = '0;
                end else begin
                    slip_d = (slip_q != '1) ? slip_q + 1'b1 : slip_q;
                end
            end
            LOCKED: begin
                if (is_tok) begin
                    idle_d = '0;
                end else begin
                    idle_d = (idle_q != '1) ? idle_q + 1'b1 : idle_q;
                end
                if (idle_d == IDLE_W'(LOCK_TIMEOUT)) begin
                    state_d = SEARCH;
                    idle_d  = '0;
                    run_d   = '0;
                    timer_d = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Output word: control bits on tokens, pixel data otherwise, all quiet while unaligned
    always_comb begin
        dout_d = '0;
        de_d   = 1'b0;
        c0_d   = 1'b0;
        c1_d   = 1'b0;
        if (locked_now) begin
            if (is_tok) begin
                c0_d = tok_c[0];
                c1_d = tok_c[1];
            end else begin
                de_d   = 1'b1;
                dout_d = dec;
                c0_d   = c0_q;
                c1_d   = c1_q;
            end
        end
    end

    // State, counters and output registers
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEARCH;
            run_q     <= '0;
            timer_q   <= '0;
            slip_q    <= '0;
            idle_q    <= '0;
            prev_q    <= '0;
            bitslip_q <= 1'b0;
            dout_q    <= '0;
            c0_q      <= 1'b0;
            c1_q      <= 1'b0;
            de_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            timer_q   <= timer_d;
            slip_q    <= slip_d;
            idle_q    <= idle_d;
            prev_q    <= din;
            bitslip_q <= bitslip_d;
            dout_q    <= dout_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            de_q      <= de_d;
        end
    end

    assign bitslip = bitslip_q;
    assign aligned = locked_now;
    assign dout    = dout_q;
    assign c0      = c0_q;
    assign c1      = c1_q;
    assign de      = de_q;

`ifdef TMDS_RX_DISP_CHECK_EN
    logic [3:0]        ones;
    logic signed [7:0] delta, acc_new;
    logic signed [6:0] acc_q, acc_d;
    logic              err_q, err_d;

    // Running disparity of aligned data words, reset by any token
    always_comb begin
        ones = '0;
        for (int i = 0; i < 10; i++) begin
            ones = ones + {3'b000, din[i]};
        end
        delta   = $signed({3'b000, ones, 1'b0}) - 8'sd10;
        acc_new = $signed({acc_q[6], acc_q}) + delta;
        if (acc_new > 8'sd63) begin
            acc_new = 8'sd63;
        end else if (acc_new < -8'sd63) begin
            acc_new = -8'sd63;
        end
        acc_d = acc_q;
        err_d = 1'b0;
        if (is_tok) begin
            acc_d = '0;
        end else if (locked_now) begin
            acc_d = acc_new[6:0];
            err_d = (acc_new > 8'sd16) || (acc_new < -8'sd16);
        end
    end

    // Disparity accumulator and error flag, aligned with dout
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            err_q <= err_d;
        end
    end

    assign disp_err = err_q;
`endif

endmodule

// File: tb/tb_tmds_channel_rx.sv
// tb/tb_tmds_channel_rx.sv - scoreboard bench for tmds_channel_rx (covers TMDS_RX_DISP_CHECK_EN when defined)
module tb_tmds_channel_rx;
    logic       pix_clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] din = '0;
    logic       bitslip, aligned, c0, c1, de;
    logic [7:0] dout;
`ifdef TMDS_RX_DISP_CHECK_EN
    logic       disp_err;
    localparam bit DISP_EN = 1'b1;
`else
    localparam bit DISP_EN = 1'b0;
`endif

    localparam logic [9:0] T00 = 10'h354, T01 = 10'h0AB, T10 = 10'h154, T11 = 10'h2AB;
    localparam logic [9:0] ROT = 10'h1AA;
    localparam logic [9:0] W00 = 10'h100, WFF = 10'h200, W10 = 10'h1F0, WA5 = 10'h39C;
    localparam logic [9:0] WP6 = 10'h3FC;

    always #5 pix_clk = ~pix_clk;

    tmds_channel_rx dut (
        .pix_clk (pix_clk),
        .rst     (rst),
        .din     (din),
        .bitslip (bitslip),
        .aligned (aligned),
        .dout    (dout),
        .c0      (c0),
        .c1      (c1),
        .de      (de)
`ifdef TMDS_RX_DISP_CHECK_EN
        ,
        .disp_err(disp_err)
`endif
    );

    typedef struct packed {
        logic       bs;
        logic       al;
        logic       de;
        logic [1:0] c;
        logic [7:0] dout;
        logic       derr;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic obs_t mk(logic bs, logic al, logic d_e, logic [1:0] c, logic [7:0] d, logic derr);
        obs_t o;
        o.bs = bs; o.al = al; o.de = d_e; o.c = c; o.dout = d; o.derr = derr;
        return o;
    endfunction

    function automatic obs_t actual();
        obs_t o;
        o.bs = bitslip; o.al = aligned; o.de = de; o.c = {c1, c0}; o.dout = dout;
`ifdef TMDS_RX_DISP_CHECK_EN
        o.derr = disp_err;
`else
        o.derr = 1'b0;
`endif
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got bs=%b al=%b de=%b c1c0=%b dout=%h derr=%b, expected bs=%b al=%b de=%b c1c0=%b dout=%h derr=%b",
                     name, got.bs, got.al, got.de, got.c, got.dout, got.derr,
                     want.bs, want.al, want.de, want.c, want.dout, want.derr);
        end
    endtask

    task automatic drive(input logic [9:0] w, input obs_t e, input string tag);
        ent_t x;
        @(negedge pix_clk);
        din = w;
        x.o = e;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    // Asserts rst between edges, checks outputs cleared without a clock, releases between edges
    task automatic do_reset(input string tag);
        @(posedge pix_clk);
        #2;
        rst = 1'b1;
        din = '0;
        #1;
        check(tag, actual(), mk(0, 0, 0, 2'b00, 8'h00, 0));
        repeat (2) @(posedge pix_clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: one expected record per clock edge consumed by the stimulus
    initial begin
        forever begin
            @(posedge pix_clk);
            #1;
            if (exp_q.size() > 0) begin
                ent_t x;
                x = exp_q.pop_front();
                check(x.tag, actual(), x.o);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        logic [9:0] wv [4];
        logic [7:0] bv [4];
        wv[0] = W00; wv[1] = WFF; wv[2] = W10; wv[3] = WA5;
        bv[0] = 8'h00; bv[1] = 8'hFF; bv[2] = 8'h10; bv[3] = 8'hA5;

        do_reset("reset_state");

        // Lock on a stream of identical tokens, then a different token
        for (int k = 1; k <= 10; k++)
            drive(T00, mk(0, k >= 8, 0, 2'b00, 8'h00, 0), $sformatf("lock_tok%0d", k));
        drive(T01, mk(0, 1, 0, 2'b01, 8'h00, 0), "tok_c01");

        // Data decode with held control bits
        for (int k = 0; k < 4; k++)
            drive(wv[k], mk(0, 1, 1, 2'b01, bv[k], 0), $sformatf("decode_%h", bv[k]));
        drive(T10, mk(0, 1, 0, 2'b10, 8'h00, 0), "tok_c10");
        drive(W10, mk(0, 1, 1, 2'b10, 8'h10, 0), "hold_c10");
        drive(T11, mk(0, 1, 0, 2'b11, 8'h00, 0), "tok_c11");

        // Disparity accumulation: +6 per word, error once past 16, cleared by a token
        drive(WP6, mk(0, 1, 1, 2'b11, 8'h05, 0), "disp_w1");
        drive(WP6, mk(0, 1, 1, 2'b11, 8'h05, 0), "disp_w2");
        drive(WP6, mk(0, 1, 1, 2'b11, 8'h05, DISP_EN), "disp_w3");
        drive(T00, mk(0, 1, 0, 2'b00, 8'h00, 0), "disp_clear_tok");
        drive(WP6, mk(0, 1, 1, 2'b00, 8'h05, 0), "disp_after_clear");
        drive(T01, mk(0, 1, 0, 2'b01, 8'h00, 0), "tok_before_loss");

        // Loss of lock after LOCK_TIMEOUT data words
        for (int j = 1; j <= 4096; j++)
            drive(W10, mk(0, j < 4096, 1, 2'b01, 8'h10, 0), $sformatf("loss_w%0d", j));
        drive(W10, mk(0, 0, 0, 2'b00, 8'h00, 0), "loss_forced");

        // Relock, then reset while locked with active outputs
        do_reset("reset_after_loss");
        for (int k = 1; k <= 9; k++)
            drive(T01, mk(0, k >= 8, 0, {1'b0, k == 9}, 8'h00, 0), $sformatf("relock_tok%0d", k));
        drive(W10, mk(0, 1, 1, 2'b01, 8'h10, 0), "relock_data");
        do_reset("reset_while_locked");

        // Misaligned stream: one bitslip after SEARCH_TIMEOUT, quiet settle, then lock
        for (int e = 1; e <= 2048; e++)
            drive(ROT, mk(e == 2048, 0, 0, 2'b00, 8'h00, 0), $sformatf("search_e%0d", e));
        for (int k = 1; k <= 4; k++)
            drive(T00, mk(0, 0, 0, 2'b00, 8'h00, 0), $sformatf("settle_%0d", k));
        for (int k = 1; k <= 8; k++)
            drive(T00, mk(0, k == 8, 0, 2'b00, 8'h00, 0), $sformatf("slip_lock_tok%0d", k));
        drive(T01, mk(0, 1, 0, 2'b01, 8'h00, 0), "slip_lock_c01");

        // Reset during the bitslip pulse, then SEARCH restarts
        do_reset("reset_pre_slip");
        for (int e = 1; e <= 2048; e++)
            drive(ROT, mk(e == 2048, 0, 0, 2'b00, 8'h00, 0), $sformatf("search2_e%0d", e));
        do_reset("reset_during_bitslip");
        for (int k = 1; k <= 8; k++)
            drive(T00, mk(0, k == 8, 0, 2'b00, 8'h00, 0), $sformatf("restart_tok%0d", k));

        repeat (3) @(posedge pix_clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
